// File: rtl/ternary_fetch_unit.sv
// Bytecode fetch/issue stage for ternary_processor: reads PUSH/ADD/MUL/HALT/NOP from a
// synchronous program memory and blocks stack overflow, underflow and PC wrap before issue.
module ternary_fetch_unit #(
  parameter int         AW          = 8,
  parameter int         STACK_DEPTH = 16,
  parameter logic [7:0] IDLE_CODE   = 8'hFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [7:0]    instr_out,
  output logic [7:0]    operand_out,
  output logic          busy,
  output logic          done,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [4:0]    depth,
  output logic [AW-1:0] pc
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_WAIT_OP   = 3'd2;
  localparam logic [2:0] S_FETCH_ARG = 3'd3;
  localparam logic [2:0] S_WAIT_ARG  = 3'd4;
  localparam logic [2:0] S_ISSUE     = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [7:0] OP_PUSH = 8'd0;
  localparam logic [7:0] OP_ADD  = 8'd1;
  localparam logic [7:0] OP_MUL  = 8'd2;
  localparam logic [7:0] OP_HALT = 8'd5;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_UNF  = 2'd2;
  localparam logic [1:0] FC_WRAP = 2'd3;

  localparam logic [4:0] DEPTH_MAX = 5'(STACK_DEPTH);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          wrap_q, wrap_d;
  logic [4:0]    depth_q, depth_d;
  logic [1:0]    fcode_q, fcode_d;
  logic [7:0]    instr_q, instr_d;
  logic [7:0]    operand_q, operand_d;
  logic [AW:0]   pc_inc;

  // Extra MSB captures the carry out of the PC so a wrap can be remembered.
  assign pc_inc = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrap_d    = wrap_q;
    depth_d   = depth_q;
    fcode_d   = fcode_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_d = S_FETCH_OP;
          pc_d    = start_addr;
          wrap_d  = 1'b0;
          depth_d = 5'd0;
          fcode_d = FC_NONE;
        end
      end
      S_FETCH_OP: begin
        if (wrap_q) begin
          state_d = S_FAULT;
          fcode_d = FC_WRAP;
        end else begin
          state_d = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        instr_d   = mem_rdata;
        operand_d = 8'h00;
        pc_d      = pc_inc[AW-1:0];
        wrap_d    = wrap_q | pc_inc[AW];
        if (mem_rdata == OP_PUSH) begin
          if (depth_q == DEPTH_MAX) begin
            state_d = S_FAULT;
            fcode_d = FC_OVF;
          end else begin
            state_d = S_FETCH_ARG;
          end
        end else if (mem_rdata == OP_ADD || mem_rdata == OP_MUL) begin
          if (depth_q < 5'd2) begin
            state_d = S_FAULT;
            fcode_d = FC_UNF;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FETCH_ARG: begin
        if (wrap_q) begin
          state_d = S_FAULT;
          fcode_d = FC_WRAP;
        end else begin
          state_d = S_WAIT_ARG;
        end
      end
      S_WAIT_ARG: begin
        operand_d = mem_rdata;
        pc_d      = pc_inc[AW-1:0];
        wrap_d    = wrap_q | pc_inc[AW];
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        // Depth only moves on the accepting handshake, so a stall never double-counts.
        if (issue_ready) begin
          if (instr_q == OP_PUSH) begin
            depth_d = depth_q + 5'd1;
          end else if (instr_q == OP_ADD || instr_q == OP_MUL) begin
            depth_d = depth_q - 5'd1;
          end
          state_d = (instr_q == OP_HALT) ? S_DONE : S_FETCH_OP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      depth_q <= 5'd0;
      fcode_q <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      depth_q <= depth_d;
      fcode_q <= fcode_d;
    end
  end

  // Instruction/operand payload is masked by issue_valid at the outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    instr_q   <= instr_d;
    operand_q <= operand_d;
  end

  assign issue_valid = (state_q == S_ISSUE);
  assign instr_out   = issue_valid ? instr_q : IDLE_CODE;
  assign operand_out = issue_valid ? operand_q : 8'h00;
  assign mem_rd      = (state_q == S_FETCH_OP || state_q == S_FETCH_ARG) && !wrap_q;
  assign mem_addr    = pc_q;
  assign busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_FAULT);
  assign done        = (state_q == S_DONE);
  assign fault       = (state_q == S_FAULT);
  assign fault_code  = fcode_q;
  assign depth       = depth_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_ternary_fetch_unit.sv
// Directed bench for ternary_fetch_unit with a synchronous program memory model.
module tb_ternary_fetch_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00;
  logic          issue_valid;
  logic          issue_ready;
  logic [7:0]    instr_out;
  logic [7:0]    operand_out;
  logic          busy;
  logic          done;
  logic          fault;
  logic [1:0]    fault_code;
  logic [4:0]    depth;
  logic [AW-1:0] pc;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0]    pmem [0:255];
  logic [7:0]    iq [$];
  logic [7:0]    oq [$];
  logic [AW-1:0] ra [$];

  always #5 clk = ~clk;

  ternary_fetch_unit #(.AW(AW), .STACK_DEPTH(16), .IDLE_CODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .instr_out(instr_out), .operand_out(operand_out),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code),
    .depth(depth), .pc(pc)
  );

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= pmem[mem_addr];
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && issue_valid && issue_ready) begin
      iq.push_back(instr_out);
      oq.push_back(operand_out);
    end
    if (rst_n && mem_rd) ra.push_back(mem_addr);
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) pmem[i] = 8'h06;
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    @(negedge clk);
    iq.delete(); oq.delete(); ra.delete();
    start = 1'b1;
    start_addr = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_addr = '0; issue_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (instr_out !== 8'hFF) begin n_bad++; $display("FAIL reset_instr got=%h exp=ff", instr_out); end
    n_vec++; if ({mem_rd, issue_valid, busy, done, fault} !== 5'b0) begin n_bad++; $display("FAIL reset_flags got=%b exp=00000", {mem_rd, issue_valid, busy, done, fault}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_vec++; if (pc !== 8'h00 || depth !== 5'd0) begin n_bad++; $display("FAIL reset_pc_depth got=%h/%0d exp=00/0", pc, depth); end
    n_vec++; if (fault_code !== 2'd0 || operand_out !== 8'h00) begin n_bad++; $display("FAIL reset_code_operand got=%0d/%h exp=0/00", fault_code, operand_out); end
    n_vec++; if (busy !== 1'b0 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_idle got=%b/%h exp=0/00", busy, mem_addr); end
  endtask

  task automatic test_basic_program();
    logic [7:0] ei [4];
    logic [7:0] eo [4];
    logic [7:0] gi, go;
    bit ok;
    ei[0] = 8'd0; ei[1] = 8'd0; ei[2] = 8'd1; ei[3] = 8'd5;
    eo[0] = 8'd3; eo[1] = 8'd4; eo[2] = 8'd0; eo[3] = 8'd0;
    clear_mem();
    pmem[16] = 8'd0; pmem[17] = 8'd3; pmem[18] = 8'd0;
    pmem[19] = 8'd4; pmem[20] = 8'd1; pmem[21] = 8'd5;
    issue_ready = 1'b1;
    pulse_start(8'h10);
    wait_quiet(100, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL basic_timeout got=busy exp=idle"); end
    n_vec++; if (iq.size() != 4) begin n_bad++; $display("FAIL basic_count got=%0d exp=4", iq.size()); end
    for (int k = 0; k < 4; k++) begin
      gi = (k < iq.size()) ? iq[k] : 8'hxx;
      go = (k < oq.size()) ? oq[k] : 8'hxx;
      n_vec++;
      if (gi !== ei[k] || go !== eo[k]) begin
        n_bad++; $display("FAIL basic_issue%0d got=(%h,%h) exp=(%h,%h)", k, gi, go, ei[k], eo[k]);
      end
    end
    n_vec++; if (done !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL basic_done got=%b/%b exp=1/0", done, fault); end
    n_vec++; if (depth !== 5'd1) begin n_bad++; $display("FAIL basic_depth got=%0d exp=1", depth); end
    n_vec++; if (pc !== 8'h16) begin n_bad++; $display("FAIL basic_pc got=%h exp=16", pc); end
  endtask

  task automatic test_stall();
    logic [7:0] ei [4];
    logic [7:0] eo [4];
    logic [7:0] gi, go;
    bit ok, found;
    ei[0] = 8'd0; ei[1] = 8'd0; ei[2] = 8'd1; ei[3] = 8'd5;
    eo[0] = 8'd3; eo[1] = 8'd4; eo[2] = 8'd0; eo[3] = 8'd0;
    issue_ready = 1'b1;
    pulse_start(8'h10);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (issue_valid && instr_out == 8'd0 && operand_out == 8'd4) begin
        issue_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    n_vec++; if (!found) begin n_bad++; $display("FAIL stall_reach got=none exp=second_push"); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++; if (instr_out !== 8'd0 || operand_out !== 8'd4) begin n_bad++; $display("FAIL stall_hold%0d got=(%h,%h) exp=(00,04)", c, instr_out, operand_out); end
      n_vec++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL stall_memrd%0d got=%b exp=0", c, mem_rd); end
      n_vec++; if (issue_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid%0d got=%b exp=1", c, issue_valid); end
    end
    issue_ready = 1'b1;
    wait_quiet(100, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL stall_timeout got=busy exp=idle"); end
    n_vec++; if (iq.size() != 4) begin n_bad++; $display("FAIL stall_count got=%0d exp=4", iq.size()); end
    for (int k = 0; k < 4; k++) begin
      gi = (k < iq.size()) ? iq[k] : 8'hxx;
      go = (k < oq.size()) ? oq[k] : 8'hxx;
      n_vec++;
      if (gi !== ei[k] || go !== eo[k]) begin
        n_bad++; $display("FAIL stall_issue%0d got=(%h,%h) exp=(%h,%h)", k, gi, go, ei[k], eo[k]);
      end
    end
    n_vec++; if (done !== 1'b1 || depth !== 5'd1) begin n_bad++; $display("FAIL stall_done got=%b/%0d exp=1/1", done, depth); end
  endtask

  task automatic test_underflow();
    bit ok;
    clear_mem();
    pmem[0] = 8'd0; pmem[1] = 8'd1; pmem[2] = 8'd2;
    pulse_start(8'h00);
    wait_quiet(100, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL unf_timeout got=busy exp=idle"); end
    n_vec++; if (fault !== 1'b1 || fault_code !== 2'd2) begin n_bad++; $display("FAIL unf_code got=%b/%0d exp=1/2", fault, fault_code); end
    n_vec++; if (depth !== 5'd1 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL unf_state got=%0d/%b/%b exp=1/0/0", depth, busy, done); end
    n_vec++; if (iq.size() != 1 || oq.size() != 1) begin n_bad++; $display("FAIL unf_count got=%0d exp=1", iq.size()); end
    else if (iq[0] !== 8'd0 || oq[0] !== 8'd1) begin n_bad++; $display("FAIL unf_issue got=(%h,%h) exp=(00,01)", iq[0], oq[0]); end
  endtask

  task automatic test_overflow();
    bit ok;
    int npush;
    clear_mem();
    for (int k = 0; k < 17; k++) begin
      pmem[2*k] = 8'd0;
      pmem[2*k+1] = 8'd1;
    end
    pmem[34] = 8'd5;
    pulse_start(8'h00);
    wait_quiet(400, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout got=busy exp=idle"); end
    npush = 0;
    foreach (iq[k]) if (iq[k] == 8'd0 && oq[k] == 8'd1) npush++;
    n_vec++; if (iq.size() != 16 || npush != 16) begin n_bad++; $display("FAIL ovf_count got=%0d/%0d exp=16/16", iq.size(), npush); end
    n_vec++; if (fault !== 1'b1 || fault_code !== 2'd1) begin n_bad++; $display("FAIL ovf_code got=%b/%0d exp=1/1", fault, fault_code); end
    n_vec++; if (depth !== 5'd16) begin n_bad++; $display("FAIL ovf_depth got=%0d exp=16", depth); end
    n_vec++; if (pc !== 8'h21 || done !== 1'b0) begin n_bad++; $display("FAIL ovf_pc got=%h/%b exp=21/0", pc, done); end
  endtask

  task automatic test_pc_wrap();
    bit ok;
    clear_mem();
    pmem[255] = 8'd7;
    pulse_start(8'hFF);
    wait_quiet(100, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL wrap_timeout got=busy exp=idle"); end
    n_vec++; if (iq.size() != 1) begin n_bad++; $display("FAIL wrap_count got=%0d exp=1", iq.size()); end
    else if (iq[0] !== 8'd7 || oq[0] !== 8'd0) begin n_bad++; $display("FAIL wrap_issue got=(%h,%h) exp=(07,00)", iq[0], oq[0]); end
    n_vec++; if (fault !== 1'b1 || fault_code !== 2'd3) begin n_bad++; $display("FAIL wrap_code got=%b/%0d exp=1/3", fault, fault_code); end
    n_vec++; if (ra.size() != 1) begin n_bad++; $display("FAIL wrap_reads got=%0d exp=1", ra.size()); end
    else if (ra[0] !== 8'hFF) begin n_bad++; $display("FAIL wrap_addr got=%h exp=ff", ra[0]); end
    n_vec++; if (pc !== 8'h00 || depth !== 5'd0) begin n_bad++; $display("FAIL wrap_pc got=%h/%0d exp=00/0", pc, depth); end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok, found;
    clear_mem();
    pmem[8'h40] = 8'd0; pmem[8'h41] = 8'd9;
    pulse_start(8'h40);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_rd && mem_addr == 8'h41) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++; if (!found) begin n_bad++; $display("FAIL rmid_reach got=none exp=fetch_arg"); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, mem_rd, issue_valid, done, fault} !== 5'b0) begin n_bad++; $display("FAIL rmid_flags got=%b exp=00000", {busy, mem_rd, issue_valid, done, fault}); end
    n_vec++; if (pc !== 8'h00 || depth !== 5'd0 || fault_code !== 2'd0) begin n_bad++; $display("FAIL rmid_regs got=%h/%0d/%0d exp=00/0/0", pc, depth, fault_code); end
    n_vec++; if (instr_out !== 8'hFF || operand_out !== 8'h00) begin n_bad++; $display("FAIL rmid_out got=(%h,%h) exp=(ff,00)", instr_out, operand_out); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mem();
    pmem[0] = 8'd5;
    pulse_start(8'h00);
    wait_quiet(100, ok);
    n_vec++; if (!ok) begin n_bad++; $display("FAIL rmid_timeout got=busy exp=idle"); end
    n_vec++; if (done !== 1'b1 || fault !== 1'b0) begin n_bad++; $display("FAIL rmid_done got=%b/%b exp=1/0", done, fault); end
    n_vec++; if (iq.size() != 1) begin n_bad++; $display("FAIL rmid_count got=%0d exp=1", iq.size()); end
    else if (iq[0] !== 8'd5) begin n_bad++; $display("FAIL rmid_issue got=%h exp=05", iq[0]); end
    n_vec++; if (pc !== 8'h01) begin n_bad++; $display("FAIL rmid_pc got=%h exp=01", pc); end
  endtask

  initial begin
    clear_mem();
    test_reset();
    test_basic_program();
    test_stall();
    test_underflow();
    test_overflow();
    test_pc_wrap();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ternary_fetch_unit.md
Name: ternary_fetch_unit

Overview:
- Bytecode fetch/issue stage that sits directly upstream of ternary_processor.
- Reads the VM bytecode stream (PUSH=0 plus an operand byte, ADD=1, MUL=2, HALT=5, all other opcodes are single-byte NOPs) from a synchronous program memory.
- Presents one instruction/operand pair per issue handshake on the processor's instruction/operand inputs.
- Shadows stack depth to block PUSH overflow, ADD/MUL underflow and PC wrap before they reach the datapath.

Parameters:
AW, 8, program memory address width in bits
STACK_DEPTH, 16, processor stack entries; overflow limit
IDLE_CODE, 8'hFF, value driven on instr_out when no instruction is issued (decodes as NOP)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begin fetching at start_addr
start_addr  input  AW  first bytecode address
mem_rd  output  1  program memory read strobe
mem_addr  output  AW  program memory address
mem_rdata  input  8  read data; valid exactly 1 cycle after mem_rd
issue_valid  output  1  instr_out/operand_out hold a valid instruction
issue_ready  input  1  consumer accepts the instruction this cycle
instr_out  output  8  opcode to processor; IDLE_CODE when issue_valid=0
operand_out  output  8  PUSH operand; 0 for non-PUSH and when idle
busy  output  1  1 in every state except IDLE/DONE/FAULT
done  output  1  HALT has been issued and accepted
fault  output  1  fetch aborted
fault_code  output  2  0 none, 1 stack overflow, 2 stack underflow, 3 PC wrap
depth  output  5  shadow stack depth
pc  output  AW  address of the next byte to fetch

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=0, depth=0, pc_wrapped=0. All outputs go low, except instr_out=IDLE_CODE. fault_code=0. Reset mid-fetch abandons the fetch; a pending memory return is ignored.
- States: IDLE, FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, ISSUE, DONE, FAULT.
- start is honoured only in IDLE, DONE and FAULT; it is ignored while busy. On start: pc<=start_addr, depth<=0, pc_wrapped<=0, done/fault/fault_code cleared, go to FETCH_OP.
- FETCH_OP: if pc_wrapped, go to FAULT with code 3. Otherwise assert mem_rd=1 with mem_addr=pc for 1 cycle, then go to WAIT_OP.
- WAIT_OP: latch mem_rdata as the opcode. pc<=pc+1; a carry out of the AW-bit PC sets pc_wrapped. Then:
  - op 0: if depth==STACK_DEPTH, go to FAULT code 1; else go to FETCH_ARG.
  - op 1 or 2: if depth<2, go to FAULT code 2; else go to ISSUE.
  - any other op: go to ISSUE.
- FETCH_ARG: same wrap check as FETCH_OP (code 3). Assert mem_rd at pc, then go to WAIT_ARG.
- WAIT_ARG: latch the operand, pc<=pc+1 (same wrap tracking), go to ISSUE.
- ISSUE: issue_valid=1. instr_out and operand_out are registered and held stable until issue_ready.
  - On issue_valid&&issue_ready: depth +1 for PUSH, −1 for ADD/MUL, unchanged otherwise.
  - HALT then goes to DONE (done=1, held). Anything else goes to FETCH_OP.
- Faulting instructions are never issued. FAULT and DONE hold until start or reset.
- HALT at address 2^AW−1 completes normally; the wrap only faults if another fetch is attempted.
- Latency (issue_ready=1 throughout): issue_valid rises 3 cycles after the start edge for 1-byte ops and 5 cycles for PUSH. Steady state is 3 cycles per 1-byte op and 5 per PUSH.
- issue_ready low stalls in ISSUE indefinitely; no memory reads occur while stalled.
- depth saturates at the checked bounds by construction and never exceeds STACK_DEPTH.

Test Plan:
- Program at 0x10: {0,3, 0,4, 1, 5}, start_addr=0x10, ready=1. Required issues: (0,3), (0,4), (1,0), (5,0). Then done=1, depth=1, pc=0x16, fault=0.
- Same program with issue_ready low for 4 cycles on the second PUSH. instr_out=0 and operand_out=4 must hold steady, mem_rd must stay 0, and issue order is unchanged.
- Program {0,1, 2}. After the PUSH issues: fault=1, fault_code=2, MUL never issued, depth=1, busy=0.
- Program of 17 PUSH 1 then HALT. Required: 16 PUSHes issued, then fault_code=1, depth=16, 17th PUSH not issued.
- AW=8, start_addr=0xFF, byte 0xFF=7 (NOP). The NOP is issued, then fault_code=3, and no mem_rd occurs at address 0x00.
- rst_n pulsed low while in WAIT_ARG. All outputs return to reset values immediately. A subsequent start at 0x00 with {5} issues HALT and sets done=1.
